// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the multicycle MIPS controller:
//   - opcode and funct field encodings of the supported instructions
//   - 4-bit ALU operation codes
//   - 2-bit ALU operation class the FSM hands to the ALU decoder
//   - controller state enumeration
// -----------------------------------------------------------------------------
package mips_pkg;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  // ALU operation class emitted by the FSM
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_ALUWB   = 4'd7,
    S_BEQ     = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11,
    S_ILLEGAL = 4'd12
  } state_t;

endpackage

// File: rtl/mips_control_fsm_alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
// Combinational translation of the FSM's ALU operation class (and, for
// R-type execution, the funct field) into the 4-bit ALU operation code.
// Ports:
//   alu_op       in  2  operation class (ADD / SUB / use funct)
//   funct        in  6  instr[5:0]
//   alu_op_code  out 4  ALU operation select
// Unknown funct values map to AND (0000); there is no funct trap.
// -----------------------------------------------------------------------------
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_op_code
);

  always_comb begin
    alu_op_code = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_op_code = ALU_ADD;
      ALUOP_SUB: alu_op_code = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_ADD:  alu_op_code = ALU_ADD;
          FN_SUB:  alu_op_code = ALU_SUB;
          FN_AND:  alu_op_code = ALU_AND;
          FN_OR:   alu_op_code = ALU_OR;
          FN_SLT:  alu_op_code = ALU_SLT;
          FN_NOR:  alu_op_code = ALU_NOR;
          default: alu_op_code = ALU_AND;
        endcase
      end
      default: alu_op_code = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_control_fsm.sv
// -----------------------------------------------------------------------------
// mips_control_fsm
// Multicycle MIPS main controller. Walks each instruction through
// fetch/decode/execute/memory/writeback and drives the datapath selects and
// write enables as Moore outputs of the current state.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   opcode, funct     instruction fields from the instruction register
//   zero              ALU zero flag (only affects pc_en)
//   alu_op_code       4-bit ALU operation
//   alu_src_a/_b      ALU operand selects
//   pc_src            next-PC select
//   i_or_d            memory address select
//   reg_dst           destination register select
//   mem_to_reg        register write data select
//   ir_write, mem_write, reg_write, pc_write, branch   enables
//   pc_en             pc_write | (branch & zero)
//   illegal_op        one-cycle pulse for an unsupported opcode
// -----------------------------------------------------------------------------
module mips_control_fsm
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [3:0] alu_op_code,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       i_or_d,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       pc_write,
  output logic       branch,
  output logic       pc_en,
  output logic       illegal_op
);

  state_t     state_reg, state_next;
  logic [1:0] alu_op;
  logic       ir_write_raw, mem_write_raw, reg_write_raw;
  logic       pc_write_raw, branch_raw, illegal_op_raw;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= S_FETCH;
    else        state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = S_FETCH;
    case (state_reg)
      S_FETCH:  state_next = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXEC;
          OP_BEQ:       state_next = S_BEQ;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JUMP;
          default:      state_next = S_ILLEGAL;
        endcase
      end
      // Only lw and sw reach MEMADR, so anything other than lw is a store.
      S_MEMADR: state_next = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_next = S_MEMWB;
      S_EXEC:   state_next = S_ALUWB;
      S_ADDIEX: state_next = S_ADDIWB;
      default:  state_next = S_FETCH;
    endcase
  end

  // Moore outputs
  always_comb begin
    alu_op         = ALUOP_ADD;
    alu_src_a      = 1'b0;
    alu_src_b      = 2'b00;
    pc_src         = 2'b00;
    i_or_d         = 1'b0;
    reg_dst        = 1'b0;
    mem_to_reg     = 1'b0;
    ir_write_raw   = 1'b0;
    mem_write_raw  = 1'b0;
    reg_write_raw  = 1'b0;
    pc_write_raw   = 1'b0;
    branch_raw     = 1'b0;
    illegal_op_raw = 1'b0;
    case (state_reg)
      S_FETCH: begin
        alu_src_b    = 2'b01;
        ir_write_raw = 1'b1;
        pc_write_raw = 1'b1;
      end
      S_DECODE: alu_src_b = 2'b11;  // branch target precompute
      S_MEMADR, S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
      end
      S_MEMRD: i_or_d = 1'b1;
      S_MEMWR: begin
        i_or_d        = 1'b1;
        mem_write_raw = 1'b1;
      end
      S_MEMWB: begin
        mem_to_reg    = 1'b1;
        reg_write_raw = 1'b1;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        reg_dst       = 1'b1;
        reg_write_raw = 1'b1;
      end
      S_ADDIWB: reg_write_raw = 1'b1;
      S_BEQ: begin
        alu_src_a  = 1'b1;
        alu_op     = ALUOP_SUB;
        pc_src     = 2'b01;
        branch_raw = 1'b1;
      end
      S_JUMP: begin
        pc_src       = 2'b10;
        pc_write_raw = 1'b1;
      end
      S_ILLEGAL: illegal_op_raw = 1'b1;
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct       (funct),
    .alu_op_code (alu_op_code)
  );

  // The state register already sits in FETCH during reset; gating the
  // enables with rst_n keeps FETCH's ir_write/pc_write from firing until
  // reset is released.
  assign ir_write   = ir_write_raw   & rst_n;
  assign mem_write  = mem_write_raw  & rst_n;
  assign reg_write  = reg_write_raw  & rst_n;
  assign pc_write   = pc_write_raw   & rst_n;
  assign branch     = branch_raw     & rst_n;
  assign illegal_op = illegal_op_raw & rst_n;
  assign pc_en      = pc_write | (branch & zero);

endmodule

// File: tb/tb_mips_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_mips_control_fsm
// Directed bench for mips_control_fsm. All outputs are packed into one vector
// and compared every cycle against a hand-written per-state output table.
// -----------------------------------------------------------------------------
module tb_mips_control_fsm;
  import mips_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic [3:0] alu_op_code;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       i_or_d, reg_dst, mem_to_reg;
  logic       ir_write, mem_write, reg_write, pc_write, branch, pc_en, illegal_op;

  int compared;
  int mismatched;

  // Expected-state tags used by the bench
  localparam int T_FETCH = 0, T_DECODE = 1, T_MEMADR = 2, T_MEMRD = 3,
                 T_MEMWB = 4, T_MEMWR = 5, T_EXEC = 6, T_ALUWB = 7,
                 T_BEQ = 8, T_ADDIEX = 9, T_ADDIWB = 10, T_JUMP = 11,
                 T_ILLEGAL = 12, T_RESET = 13;

  mips_control_fsm dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .funct       (funct),
    .zero        (zero),
    .alu_op_code (alu_op_code),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .pc_src      (pc_src),
    .i_or_d      (i_or_d),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .ir_write    (ir_write),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .pc_write    (pc_write),
    .branch      (branch),
    .pc_en       (pc_en),
    .illegal_op  (illegal_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [18:0] observed();
    return {alu_op_code, alu_src_a, alu_src_b, pc_src, i_or_d, reg_dst,
            mem_to_reg, ir_write, mem_write, reg_write, pc_write, branch,
            pc_en, illegal_op};
  endfunction

  // Hand-written expected outputs for each state.
  function automatic logic [18:0] expv(input int st, input logic [3:0] exec_alu,
                                       input logic z);
    logic [3:0] alu;
    logic       a, iod, rd, m2r, irw, mw, rw, pw, br, pe, ill;
    logic [1:0] b, ps;
    alu = 4'b0010; a = 0; b = 2'b00; ps = 2'b00; iod = 0; rd = 0; m2r = 0;
    irw = 0; mw = 0; rw = 0; pw = 0; br = 0; pe = 0; ill = 0;
    case (st)
      T_FETCH:   begin b = 2'b01; irw = 1; pw = 1; pe = 1; end
      T_RESET:   b = 2'b01;
      T_DECODE:  b = 2'b11;
      T_MEMADR,
      T_ADDIEX:  begin a = 1; b = 2'b10; end
      T_MEMRD:   iod = 1;
      T_MEMWR:   begin iod = 1; mw = 1; end
      T_MEMWB:   begin m2r = 1; rw = 1; end
      T_EXEC:    begin a = 1; alu = exec_alu; end
      T_ALUWB:   begin rd = 1; rw = 1; end
      T_ADDIWB:  rw = 1;
      T_BEQ:     begin alu = 4'b0110; a = 1; ps = 2'b01; br = 1; pe = z; end
      T_JUMP:    begin ps = 2'b10; pw = 1; pe = 1; end
      T_ILLEGAL: ill = 1;
      default: ;
    endcase
    return {alu, a, b, ps, iod, rd, m2r, irw, mw, rw, pw, br, pe, ill};
  endfunction

  task automatic check_val(input string tag, input logic [18:0] got,
                           input logic [18:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Entered at a falling edge with the DUT in FETCH; returns at the falling
  // edge where the next FETCH is current.
  task automatic run_instr(input string name, input logic [5:0] op,
                           input logic [5:0] fn, input logic z,
                           input logic [3:0] exec_alu,
                           input int seq[6], input int n);
    opcode = op; funct = fn; zero = z;
    for (int i = 0; i < n; i++) begin
      #1;
      check_val($sformatf("%s_c%0d", name, i + 1), observed(),
                expv(seq[i], exec_alu, z));
      @(negedge clk);
    end
    $display("instr %-8s op=%b funct=%b zero=%b cycles=%0d", name, op, fn, z, n);
  endtask

  int seq_lw[6]   = '{T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB, T_FETCH};
  int seq_sw[6]   = '{T_FETCH, T_DECODE, T_MEMADR, T_MEMWR, T_FETCH, T_FETCH};
  int seq_r[6]    = '{T_FETCH, T_DECODE, T_EXEC, T_ALUWB, T_FETCH, T_FETCH};
  int seq_addi[6] = '{T_FETCH, T_DECODE, T_ADDIEX, T_ADDIWB, T_FETCH, T_FETCH};
  int seq_beq[6]  = '{T_FETCH, T_DECODE, T_BEQ, T_FETCH, T_FETCH, T_FETCH};
  int seq_j[6]    = '{T_FETCH, T_DECODE, T_JUMP, T_FETCH, T_FETCH, T_FETCH};
  int seq_ill[6]  = '{T_FETCH, T_DECODE, T_ILLEGAL, T_FETCH, T_FETCH, T_FETCH};

  logic [5:0] r_fn[7]  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                           6'b101010, 6'b100111, 6'b110011};
  logic [3:0] r_alu[7] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001,
                           4'b0111, 4'b1100, 4'b0000};

  initial begin
    compared = 0; mismatched = 0;
    rst_n = 1'b0; opcode = 6'b100011; funct = 6'b000000; zero = 1'b0;

    // Held in reset: enables off, FETCH selects visible
    repeat (2) begin
      @(negedge clk); #1;
      check_val("reset_hold", observed(), expv(T_RESET, 4'b0000, 1'b0));
    end
    @(negedge clk);
    rst_n = 1'b1;

    run_instr("lw", 6'b100011, 6'b000000, 1'b0, 4'b0000, seq_lw, 5);
    run_instr("sw", 6'b101011, 6'b000000, 1'b1, 4'b0000, seq_sw, 4);
    for (int k = 0; k < 7; k++)
      run_instr($sformatf("r%0d", k), 6'b000000, r_fn[k], 1'b0, r_alu[k], seq_r, 4);
    run_instr("addi", 6'b001000, 6'b100010, 1'b0, 4'b0000, seq_addi, 4);
    run_instr("beq_z1", 6'b000100, 6'b000000, 1'b1, 4'b0000, seq_beq, 3);
    run_instr("beq_z0", 6'b000100, 6'b000000, 1'b0, 4'b0000, seq_beq, 3);
    run_instr("j", 6'b000010, 6'b000000, 1'b0, 4'b0000, seq_j, 3);
    run_instr("illegal", 6'b111111, 6'b000000, 1'b0, 4'b0000, seq_ill, 3);

    // lw interrupted by reset while in MEMRD
    run_instr("lw_part", 6'b100011, 6'b000000, 1'b0, 4'b0000, seq_lw, 3);
    #1;
    check_val("abort_memrd", observed(), expv(T_MEMRD, 4'b0000, 1'b0));
    rst_n = 1'b0;
    #1;
    check_val("abort_rst_now", observed(), expv(T_RESET, 4'b0000, 1'b0));
    @(negedge clk); #1;
    check_val("abort_rst_hold", observed(), expv(T_RESET, 4'b0000, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    run_instr("lw_after", 6'b100011, 6'b000000, 1'b0, 4'b0000, seq_lw, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
